// File: rtl/trace_dump_ctrl.sv
// rtl/trace_dump_ctrl.sv - trace buffer readout engine emitting framed byte stream
`timescale 1ns/1ps

module trace_dump_ctrl #(
  parameter int         Fpay      = 32,
  parameter int         TB_Depth  = 512,
  parameter int         MAX_WORDS = 512,
  parameter logic [7:0] HDR       = 8'hA5,
  localparam int        CNTw      = $clog2(TB_Depth + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dump_req,
  output logic            busy,
  input  logic [CNTw-1:0] tb_count,
  output logic            tb_rd,
  input  logic [Fpay-1:0] tb_dout,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int NB   = Fpay / 8;
  localparam int IDXw = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_CNT_HI = 3'd2;
  localparam logic [2:0] S_CNT_LO = 3'd3;
  localparam logic [2:0] S_RD     = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_BYTES  = 3'd6;
  localparam logic [2:0] S_CSUM   = 3'd7;

  logic [2:0]      state;
  logic [15:0]     n_words;
  logic [15:0]     remaining;
  logic [Fpay-1:0] word_reg;
  logic [IDXw-1:0] idx;
  logic [7:0]      csum;

  logic            hs;
  logic [7:0]      csum_fold;
  logic [IDXw-1:0] idx_m1;
  logic [15:0]     n_snap;

  assign busy = (state != S_IDLE);

  // Handshake, running checksum including the byte on the bus, next byte index
  // and the clamped occupancy snapshot.
  always_comb begin
    hs        = out_valid & out_ready;
    csum_fold = csum ^ out_data;
    idx_m1    = idx - IDXw'(1);
    n_snap    = (int'(tb_count) > MAX_WORDS) ? 16'(MAX_WORDS) : 16'(tb_count);
  end

  // Frame sequencer; all outputs are registered here. The byte following a
  // handshake is loaded on the same edge, so the stream can run at one byte
  // per cycle, and a stalled byte simply holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      tb_rd     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      csum      <= 8'h00;
      n_words   <= 16'd0;
      remaining <= 16'd0;
      word_reg  <= '0;
      idx       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dump_req) begin
            n_words   <= n_snap;
            remaining <= n_snap;
            csum      <= 8'h00;
            out_data  <= HDR;
            out_valid <= 1'b1;
            state     <= S_HDR;
          end
        end
        S_HDR: begin
          if (hs) begin
            out_data <= n_words[15:8];
            state    <= S_CNT_HI;
          end
        end
        S_CNT_HI: begin
          if (hs) begin
            csum     <= csum_fold;
            out_data <= n_words[7:0];
            state    <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (hs) begin
            csum <= csum_fold;
            if (n_words == 16'd0) begin
              out_data <= csum_fold;
              state    <= S_CSUM;
            end else begin
              out_valid <= 1'b0;
              tb_rd     <= 1'b1;
              state     <= S_RD;
            end
          end
        end
        S_RD: begin
          tb_rd <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          word_reg  <= tb_dout;
          idx       <= IDXw'(NB - 1);
          out_data  <= tb_dout[Fpay-1 -: 8];
          out_valid <= 1'b1;
          state     <= S_BYTES;
        end
        S_BYTES: begin
          if (hs) begin
            csum <= csum_fold;
            if (idx == '0) begin
              remaining <= remaining - 16'd1;
              if (remaining != 16'd1) begin
                out_valid <= 1'b0;
                tb_rd     <= 1'b1;
                state     <= S_RD;
              end else begin
                out_data <= csum_fold;
                state    <= S_CSUM;
              end
            end else begin
              idx      <= idx_m1;
              out_data <= word_reg[8*idx_m1 +: 8];
            end
          end
        end
        S_CSUM: begin
          if (hs) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_dump_ctrl.sv
// tb/tb_trace_dump_ctrl.sv - randomized self-checking bench for trace_dump_ctrl
`timescale 1ns/1ps

module tb_trace_dump_ctrl;

  localparam int         FPAY   = 32;
  localparam int         DEPTH  = 512;
  localparam int         MAXW   = 4;
  localparam int         CNTW   = $clog2(DEPTH + 1);
  localparam int         NBYTES = FPAY / 8;
  localparam logic [7:0] HDRB   = 8'hA5;

  typedef logic [7:0] bq_t[$];

  logic            clk = 1'b0;
  logic            reset;
  logic            dump_req;
  logic            busy;
  logic [CNTW-1:0] tb_count;
  logic            tb_rd;
  logic [FPAY-1:0] tb_dout;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready;

  int checks = 0;
  int errors = 0;

  logic [FPAY-1:0] mem [0:1023];
  int rd_ptr = 0;

  bq_t got;
  int  rd_pulses, busy_cycles, busy_falls, stab_err, overlap_err, wide_err;
  int  first_busy_iter;
  bit  timed_out;

  trace_dump_ctrl #(
    .Fpay(FPAY), .TB_Depth(DEPTH), .MAX_WORDS(MAXW), .HDR(HDRB)
  ) dut (
    .clk(clk), .reset(reset), .dump_req(dump_req), .busy(busy),
    .tb_count(tb_count), .tb_rd(tb_rd), .tb_dout(tb_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Trace buffer read port: data valid only in the cycle after tb_rd, garbage otherwise.
  always @(posedge clk) begin
    if (tb_rd) begin
      tb_dout <= mem[rd_ptr % 1024];
      rd_ptr  <= rd_ptr + 1;
    end else begin
      tb_dout <= $urandom;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic bq_t model_frame(input int cnt, input int base);
    bq_t q;
    int n;
    logic [7:0] x;
    logic [FPAY-1:0] w;
    n = (cnt > MAXW) ? MAXW : cnt;
    q.push_back(HDRB);
    q.push_back(8'(n >> 8));
    q.push_back(8'(n));
    x = 8'(n >> 8) ^ 8'(n);
    for (int i = 0; i < n; i++) begin
      w = mem[(base + i) % 1024];
      for (int b = NBYTES - 1; b >= 0; b--) begin
        q.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
    q.push_back(x);
    return q;
  endfunction

  function automatic int first_diff(input bq_t a, input bq_t b);
    int m;
    m = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < m; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return m;
    return -1;
  endfunction

  task automatic fill_words(input int k);
    for (int i = 0; i < k; i++) mem[(rd_ptr + i) % 1024] = $urandom;
  endtask

  task automatic run_frame(input int cnt, input int ready_pct, input bit re_req);
    logic pb, prd, ps;
    logic [7:0] pd;
    bit done_re;
    int after;
    got.delete();
    rd_pulses = 0; busy_cycles = 0; busy_falls = 0;
    stab_err = 0; overlap_err = 0; wide_err = 0;
    first_busy_iter = -1; timed_out = 0;
    pb = 1'b0; prd = 1'b0; ps = 1'b0; pd = 8'h00; done_re = 0; after = -1;
    for (int it = 0; it < 4000; it++) begin
      @(posedge clk); #1;
      dump_req = (it == 0);
      if (it == 0) tb_count = CNTW'(cnt);
      if (re_req && !done_re && got.size() >= 4) begin
        dump_req = 1'b1;
        tb_count = CNTW'($urandom_range(0, DEPTH));
        done_re  = 1;
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      @(negedge clk);
      if (busy && first_busy_iter < 0) first_busy_iter = it;
      if (pb && !busy) busy_falls++;
      if (busy) busy_cycles++;
      if (tb_rd) rd_pulses++;
      if (tb_rd && prd) wide_err++;
      if (tb_rd && out_valid) overlap_err++;
      if (ps && (!out_valid || out_data !== pd)) stab_err++;
      ps = out_valid && !out_ready;
      pd = out_data;
      if (out_valid && out_ready) got.push_back(out_data);
      pb = busy;
      prd = tb_rd;
      if (first_busy_iter >= 0 && !busy && after < 0) after = 0;
      if (after >= 0) begin
        after++;
        if (after > 12) break;
      end
    end
    if (after < 0) timed_out = 1;
    dump_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; dump_req = 1'b1; out_ready = 1'b1; tb_count = CNTW'(3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (tb_rd !== 1'b0) begin errors++; $display("FAIL reset_tb_rd: got %b, required 0", tb_rd); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, required 00", out_data); end
    dump_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_wins: busy got %b, required 0", busy); end
  endtask

  task automatic test_empty();
    bq_t exp;
    exp = model_frame(0, rd_ptr);
    run_frame(0, 100, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL empty_timeout: frame did not end"); end
    checks++;
    if (first_diff(got, exp) != -1) begin
      errors++;
      $display("FAIL empty_stream: got %p, required %p", got, exp);
    end
    checks++; if (rd_pulses != 0) begin errors++; $display("FAIL empty_rd: got %0d pulses, required 0", rd_pulses); end
    checks++; if (busy_cycles != 4) begin errors++; $display("FAIL empty_busy: got %0d cycles, required 4", busy_cycles); end
  endtask

  task automatic load_two_words();
    mem[rd_ptr % 1024]       = 32'h11223344;
    mem[(rd_ptr + 1) % 1024] = 32'hDEADBEEF;
  endtask

  task automatic test_two_words();
    bq_t exp;
    load_two_words();
    exp = model_frame(2, rd_ptr);
    run_frame(2, 100, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL two_timeout: frame did not end"); end
    checks++;
    if (first_diff(got, exp) != -1) begin
      errors++;
      $display("FAIL two_stream: got %p, required %p", got, exp);
    end
    checks++;
    if (got.size() != 12 || got[11] !== 8'h64) begin
      errors++;
      $display("FAIL two_csum: got size %0d last %h, required size 12 last 64", got.size(),
               (got.size() > 0) ? got[got.size()-1] : 8'h00);
    end
    checks++; if (rd_pulses != 2) begin errors++; $display("FAIL two_rd: got %0d pulses, required 2", rd_pulses); end
    checks++; if (wide_err != 0) begin errors++; $display("FAIL two_rd_width: got %0d wide pulses, required 0", wide_err); end
    checks++; if (busy_cycles != 16) begin errors++; $display("FAIL two_busy: got %0d cycles, required 16", busy_cycles); end
    checks++; if (first_busy_iter != 1) begin errors++; $display("FAIL two_latency: got iter %0d, required 1", first_busy_iter); end
  endtask

  task automatic test_backpressure();
    bq_t exp;
    load_two_words();
    exp = model_frame(2, rd_ptr);
    run_frame(2, 50, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout: frame did not end"); end
    checks++;
    if (first_diff(got, exp) != -1) begin
      errors++;
      $display("FAIL bp_stream: got %p, required %p", got, exp);
    end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls, required 0", stab_err); end
    checks++; if (overlap_err != 0) begin errors++; $display("FAIL bp_overlap: got %0d rd-while-valid, required 0", overlap_err); end
  endtask

  task automatic test_clamp();
    bq_t exp;
    fill_words(MAXW + 2);
    exp = model_frame(DEPTH, rd_ptr);
    run_frame(DEPTH, 100, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL clamp_timeout: frame did not end"); end
    checks++;
    if (got.size() < 3 || got[1] !== 8'h00 || got[2] !== 8'h04) begin
      errors++;
      $display("FAIL clamp_count: got %p, required count bytes 00 04", got);
    end
    checks++;
    if (first_diff(got, exp) != -1) begin
      errors++;
      $display("FAIL clamp_stream: got %p, required %p", got, exp);
    end
    checks++; if (rd_pulses != MAXW) begin errors++; $display("FAIL clamp_rd: got %0d pulses, required %0d", rd_pulses, MAXW); end
  endtask

  task automatic test_req_while_busy();
    bq_t exp;
    fill_words(3);
    exp = model_frame(3, rd_ptr);
    run_frame(3, 100, 1);
    checks++; if (timed_out) begin errors++; $display("FAIL rwb_timeout: frame did not end"); end
    checks++;
    if (first_diff(got, exp) != -1) begin
      errors++;
      $display("FAIL rwb_stream: got %p, required %p", got, exp);
    end
    checks++; if (busy_falls != 1) begin errors++; $display("FAIL rwb_falls: got %0d busy drops, required 1", busy_falls); end
    checks++;
    if (busy_cycles != 4 + 3 * (NBYTES + 2)) begin
      errors++;
      $display("FAIL rwb_busy: got %0d cycles, required %0d", busy_cycles, 4 + 3 * (NBYTES + 2));
    end
  endtask

  task automatic test_reset_mid();
    bq_t exp, exp2;
    int it, rdc;
    load_two_words();
    exp = model_frame(2, rd_ptr);
    @(posedge clk); #1;
    tb_count = CNTW'(2); dump_req = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    got.delete();
    it = 0;
    while (got.size() < 4 && it < 100) begin
      @(negedge clk);
      if (out_valid && out_ready) got.push_back(out_data);
      it++;
    end
    checks++; if (got.size() < 4) begin errors++; $display("FAIL rst_reach: got %0d bytes, required 4", got.size()); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (!out_valid || out_data !== exp[4]) begin
      errors++;
      $display("FAIL rst_byte2: got valid %b data %h, required valid 1 data %h", out_valid, out_data, exp[4]);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b, required 0", out_valid); end
    checks++; if (tb_rd !== 1'b0) begin errors++; $display("FAIL rst_mid_rd: got %b, required 0", tb_rd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b, required 0", busy); end
    rdc = 0;
    repeat (10) begin
      @(negedge clk);
      if (tb_rd || busy) rdc++;
    end
    checks++; if (rdc != 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d active cycles, required 0", rdc); end
    fill_words(3);
    exp2 = model_frame(3, rd_ptr);
    run_frame(3, 100, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL rst_fresh_timeout: frame did not end"); end
    checks++;
    if (first_diff(got, exp2) != -1) begin
      errors++;
      $display("FAIL rst_fresh_stream: got %p, required %p", got, exp2);
    end
  endtask

  task automatic test_random();
    bq_t exp;
    int cnt, pct, nexp;
    for (int f = 0; f < 6; f++) begin
      cnt = $urandom_range(0, 6);
      pct = $urandom_range(30, 100);
      nexp = (cnt > MAXW) ? MAXW : cnt;
      fill_words(6);
      exp = model_frame(cnt, rd_ptr);
      run_frame(cnt, pct, 0);
      checks++;
      if (timed_out || first_diff(got, exp) != -1) begin
        errors++;
        $display("FAIL rand_stream[%0d]: cnt %0d got %p, required %p", f, cnt, got, exp);
      end
      checks++; if (rd_pulses != nexp) begin errors++; $display("FAIL rand_rd[%0d]: got %0d pulses, required %0d", f, rd_pulses, nexp); end
      checks++;
      if (stab_err != 0 || overlap_err != 0) begin
        errors++;
        $display("FAIL rand_proto[%0d]: got %0d unstable, %0d overlap, required 0", f, stab_err, overlap_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_two_words();
    test_backpressure();
    test_clamp();
    test_req_while_busy();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
